iq_issue_ctrl: RTL

- Control side of one issue queue; the consumer of the per-entry ready_to_go/valid status and the producer of the per-entry enq_valid/issuing strobes.
- Allocates free entries to dispatch and selects the oldest ready entry by ROB age each cycle.
- Registers the selected entry index/robid into a one-deep issue stage with valid/ready handshake toward the functional unit.
- Sits between dispatch, the array of ENTRIES queue entries, and the FU read/execute stage.

---
 rtl/isq_pkg.sv | 24 ++
 rtl/iq_issue_ctrl_if.sv | 16 +
 rtl/iq_age_select.sv | 35 +++
 rtl/iq_issue_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/isq_pkg.sv
// Shared issue-queue definitions: queue sizing, robid type and the wrap-aware
// ROB age comparison that the ROB and LSQ also use.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 5
`endif

package isq_pkg;

    localparam int ISQ_ENTRIES  = 8;
    localparam int ISQ_IDX_W    = $clog2(ISQ_ENTRIES);
    localparam int ROB_SIZE_LOG = `ROB_SIZE_LOG;
    localparam int ROBID_W      = ROB_SIZE_LOG + 1;

    typedef logic [ROBID_W-1:0] robid_t;

    // The MSB is the wrap bit: once the two ids sit on different laps, the larger low part is older.
    function automatic logic robid_older(input robid_t a, input robid_t b);
        if (a[ROBID_W-1] == b[ROBID_W-1])
            return a[ROBID_W-2:0] < b[ROBID_W-2:0];
        else
            return a[ROBID_W-2:0] > b[ROBID_W-2:0];
    endfunction

endpackage

// File: rtl/iq_issue_ctrl_if.sv
// Issue-stage handshake between the issue queue control and the functional unit.
interface iq_issue_ctrl_if
    import isq_pkg::*;
#(
    parameter int IDX_W = ISQ_IDX_W
) ();

    logic             issue_valid;
    logic [IDX_W-1:0] issue_idx;
    robid_t           issue_robid;
    logic             issue_ready;

    modport master (output issue_valid, output issue_idx, output issue_robid, input issue_ready);
    modport slave  (input issue_valid, input issue_idx, input issue_robid, output issue_ready);

endinterface

// File: rtl/iq_age_select.sv
// Combinational oldest-candidate picker: a one-hot select of the oldest entry
// by ROB age, with ties going to the lower index.
module iq_age_select
    import isq_pkg::*;
#(
    parameter int ENTRIES = ISQ_ENTRIES
) (
    input  logic [ENTRIES-1:0]         cand,
    input  logic [ENTRIES*ROBID_W-1:0] robid,
    output logic [ENTRIES-1:0]         sel,
    output logic                       sel_valid
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [IDX_W-1:0] best_idx;
    robid_t           best_robid;

    // NOTE: every variable gets a default before the loop, so no latch is inferred.
    always_comb begin
        sel        = '0;
        sel_valid  = 1'b0;
        best_idx   = '0;
        best_robid = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (cand[i] && (!sel_valid || robid_older(robid[i*ROBID_W +: ROBID_W], best_robid))) begin
                sel_valid  = 1'b1;
                best_idx   = IDX_W'(i);
                best_robid = robid[i*ROBID_W +: ROBID_W];
            end
        end
        sel[best_idx] = sel_valid;
    end

endmodule

// File: rtl/iq_issue_ctrl.sv
// Issue queue control: allocates free entries to dispatch, picks the oldest
// ready entry and holds it in a one-deep issue stage toward the FU.
module iq_issue_ctrl
    import isq_pkg::*;
#(
    parameter int ENTRIES = ISQ_ENTRIES,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       alloc_req,
    output logic                       alloc_ready,
    output logic [ENTRIES-1:0]         enq_valid,
    input  logic [ENTRIES-1:0]         entry_valid,
    input  logic [ENTRIES-1:0]         entry_ready,
    input  logic [ENTRIES*ROBID_W-1:0] entry_robid,
    output logic [ENTRIES-1:0]         issuing,
    iq_issue_ctrl_if.master            bus,
    output logic [IDX_W:0]             occupancy
);

    logic [ENTRIES-1:0] free_oh;
    logic [ENTRIES-1:0] sel;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               can_adv;
    logic               issue_fire;

    iq_age_select #(.ENTRIES(ENTRIES)) u_age_select (
        .cand      (entry_valid & entry_ready),
        .robid     (entry_robid),
        .sel       (sel),
        .sel_valid (sel_valid)
    );

    // Lowest free index wins; an entry issuing now still shows valid, so it is not reused this cycle.
    always_comb begin
        free_oh = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!entry_valid[i] && (free_oh == '0))
                free_oh[i] = 1'b1;
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (sel[i])
                sel_idx = sel_idx | IDX_W'(i);
        end
    end

    assign alloc_ready = |(~entry_valid);
    assign enq_valid   = (alloc_req && !flush) ? free_oh : '0;
    assign can_adv     = !bus.issue_valid || bus.issue_ready;
    assign issue_fire  = can_adv && sel_valid && !flush;
    assign issuing     = issue_fire ? sel : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.issue_valid <= 1'b0;
            bus.issue_idx   <= '0;
            bus.issue_robid <= '0;
            occupancy       <= '0;
        end else if (flush) begin
            bus.issue_valid <= 1'b0;
            occupancy       <= '0;
        end else begin
            if (issue_fire) begin
                bus.issue_valid <= 1'b1;
                bus.issue_idx   <= sel_idx;
                bus.issue_robid <= entry_robid[sel_idx*ROBID_W +: ROBID_W];
            end else if (bus.issue_valid && bus.issue_ready) begin
                bus.issue_valid <= 1'b0;
            end
            occupancy <= occupancy + (IDX_W+1)'(|enq_valid) - (IDX_W+1)'(|issuing);
        end
    end

    a_issuing_onehot: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(issuing));
    a_enq_onehot:     assert property (@(posedge clock) disable iff (!reset_n) $onehot0(enq_valid));
    a_issuing_cand:   assert property (@(posedge clock) disable iff (!reset_n)
                                       (issuing & ~(entry_valid & entry_ready)) == '0);
    a_enq_free:       assert property (@(posedge clock) disable iff (!reset_n) (enq_valid & entry_valid) == '0);
    a_occ_track:      assert property (@(posedge clock) disable iff (!reset_n)
                                       int'(occupancy) == $countones(entry_valid));

endmodule
